// File: rtl/seven_seg_rx.sv
// seven_seg_rx: recovers bytes from a multiplexed active-low seven-segment Pmod bus.
// Ports:
//   clk        system clock
//   nrst       synchronous active-low reset
//   seg_in     [6:0] segments a..g (0 = lit), [7] digit select (0 = MSB, 1 = LSB); asynchronous
//   dout       last completed byte {msb nibble, lsb nibble}
//   dout_valid one-cycle pulse, dout updated in the same cycle
//   err        one-cycle pulse when an accepted pattern is not a hex digit or blank
//   stale      level, no digit accepted for TIMEOUT_CYCLES cycles
module seven_seg_rx #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] seg_in,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       err,
    output logic       stale
);
    typedef enum logic {WAIT_MSB, WAIT_LSB} state_t;
    localparam logic [15:0] CNT_MAX  = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] CNT_HIT  = 16'(STABLE_CYCLES - 2);
    localparam logic [23:0] IDLE_MAX = 24'(TIMEOUT_CYCLES);
    logic [7:0]  meta, s, p, raw;
    logic [15:0] cnt;
    logic [23:0] idle;
    logic        hit, acc1, acc2;
    logic [3:0]  nib_d, nib, msb, msb_d;
    logic        ok_d, ok, blank_d, blank, sel;
    logic [7:0]  dout_d;
    logic        valid_d, err_d;
    state_t      state, state_d;

    // Fires only on the transition into the saturated count, so a long run is accepted once.
    assign hit = (s == p) && (cnt == CNT_HIT);

    always_comb begin
        ok_d    = 1'b1;
        blank_d = 1'b0;
        nib_d   = 4'h0;
        case (~raw[6:0])
            7'b0111111: nib_d = 4'h0;
            7'b0000110: nib_d = 4'h1;
            7'b1011011: nib_d = 4'h2;
            7'b1001111: nib_d = 4'h3;
            7'b1100110: nib_d = 4'h4;
            7'b1101101: nib_d = 4'h5;
            7'b1111101: nib_d = 4'h6;
            7'b0000111: nib_d = 4'h7;
            7'b1111111: nib_d = 4'h8;
            7'b1101111: nib_d = 4'h9;
            7'b1110111: nib_d = 4'hA;
            7'b1111100: nib_d = 4'hB;
            7'b0111001: nib_d = 4'hC;
            7'b1011110: nib_d = 4'hD;
            7'b1111001: nib_d = 4'hE;
            7'b1110001: nib_d = 4'hF;
            7'b0000000: blank_d = 1'b1;
            default:    ok_d = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state;
        msb_d   = msb;
        dout_d  = dout;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (acc2) begin
            if (!ok) begin
                err_d   = 1'b1;
                state_d = WAIT_MSB;
            end else if (blank) begin
                state_d = WAIT_MSB;
            end else if (!sel) begin
                msb_d   = nib;
                state_d = WAIT_LSB;
            end else if (state == WAIT_LSB) begin
                dout_d  = {msb, nib};
                valid_d = 1'b1;
                state_d = WAIT_MSB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            meta       <= 8'hFF;
            s          <= 8'hFF;
            p          <= 8'hFF;
            raw        <= 8'hFF;
            cnt        <= '0;
            idle       <= '0;
            acc1       <= 1'b0;
            acc2       <= 1'b0;
            nib        <= '0;
            ok         <= 1'b0;
            blank      <= 1'b0;
            sel        <= 1'b0;
            msb        <= '0;
            state      <= WAIT_MSB;
            dout       <= '0;
            dout_valid <= 1'b0;
            err        <= 1'b0;
            stale      <= 1'b0;
        end else begin
            meta       <= seg_in;
            s          <= meta;
            p          <= s;
            cnt        <= (s != p) ? '0 : (cnt == CNT_MAX) ? cnt : cnt + 16'd1;
            acc1       <= hit;
            raw        <= s;
            acc2       <= acc1;
            nib        <= nib_d;
            ok         <= ok_d;
            blank      <= blank_d;
            sel        <= raw[7];
            idle       <= acc2 ? '0 : (idle == IDLE_MAX) ? idle : idle + 24'd1;
            // Sampled from the pre-clear idle, so stale drops one edge after an acceptance.
            stale      <= (idle == IDLE_MAX);
            msb        <= msb_d;
            state      <= state_d;
            dout       <= dout_d;
            dout_valid <= valid_d;
            err        <= err_d;
        end
    end
endmodule

// File: tb/tb_seven_seg_rx.sv
// tb_seven_seg_rx: directed, table-driven self-checking bench for seven_seg_rx.
// Ports: none; drives clk, nrst and seg_in into the default-parameter DUT.
module tb_seven_seg_rx;
    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] seg_in = 8'hFF;
    logic [7:0] dout;
    logic       dout_valid, err, stale;

    typedef struct {
        logic [7:0] seg;
        logic [7:0] dout;
        int         nv;
        int         ne;
    } vec_t;

    vec_t tbl[28];
    int   cyc = 0;
    int   nv = 0, ne = 0, first_v = -1, rise_c = -1, fall_c = -1;
    logic stale_q = 1'b0;
    int   checks = 0, errors = 0;
    int   t0, t1;

    seven_seg_rx dut (
        .clk(clk),
        .nrst(nrst),
        .seg_in(seg_in),
        .dout(dout),
        .dout_valid(dout_valid),
        .err(err),
        .stale(stale)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dout_valid) begin
            nv++;
            if (first_v < 0) first_v = cyc;
        end
        if (err) ne++;
        if (stale && !stale_q) rise_c = cyc;
        if (!stale && stale_q) fall_c = cyc;
        stale_q = stale;
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clr();
        nv = 0;
        ne = 0;
        first_v = -1;
    endtask

    initial begin
        tbl = '{
            '{8'h19, 8'h42, 0, 0}, '{8'hBF, 8'h42, 0, 1}, '{8'h79, 8'h42, 0, 0}, '{8'hF8, 8'h17, 1, 0},
            '{8'h92, 8'h17, 0, 0}, '{8'h30, 8'h17, 0, 0}, '{8'h10, 8'h17, 0, 0}, '{8'h86, 8'h9E, 1, 0},
            '{8'h46, 8'h9E, 0, 0}, '{8'h7F, 8'h9E, 0, 0}, '{8'hA1, 8'h9E, 0, 0}, '{8'h08, 8'h9E, 0, 0},
            '{8'h83, 8'hAB, 1, 0}, '{8'h02, 8'hAB, 0, 0}, '{8'h80, 8'h68, 1, 0}, '{8'h21, 8'h68, 0, 0},
            '{8'h3F, 8'h68, 0, 1}, '{8'h8E, 8'h68, 0, 0}, '{8'h40, 8'h68, 0, 0}, '{8'h7E, 8'h68, 0, 1},
            '{8'h0E, 8'h68, 0, 0}, '{8'h86, 8'hFE, 1, 0}, '{8'h0E, 8'hFE, 0, 0}, '{8'h8E, 8'hFF, 1, 0},
            '{8'h40, 8'hFF, 0, 0}, '{8'hC0, 8'h00, 1, 0}, '{8'h40, 8'h00, 0, 0}, '{8'hF9, 8'h01, 1, 0}
        };
        clr();
        for (int i = 0; i < 3; i++) begin
            seg_in = 8'($urandom);
            tick(1);
            chk("reset dout", dout, 0);
            chk("reset pulses/stale", {dout_valid, err, stale}, 0);
        end
        nrst = 1'b1;
        seg_in = 8'hFF;
        tick(1);
        chk("release dout", dout, 0);
        chk("release dout_valid", dout_valid, 0);
        chk("release err", err, 0);
        chk("release stale", stale, 0);
        chk("reset window pulses", nv + ne, 0);

        seg_in = 8'h19;
        tick(64);
        clr();
        t0 = cyc;
        seg_in = 8'hA4;
        tick(40);
        chk("basic latency", first_v - t0, 20);
        chk("basic dout", dout, 8'h42);
        chk("basic valid count", nv, 1);
        chk("basic err count", ne, 0);

        seg_in = 8'h19;
        tick(24);
        clr();
        for (int i = 0; i < 62; i++) begin
            seg_in = (i % 2 == 1) ? 8'hB0 : 8'hA4;
            tick(8);
        end
        chk("glitch valid count", nv, 0);
        chk("glitch err count", ne, 0);
        seg_in = 8'h7F;
        tick(24);
        chk("blank drop valid count", nv, 0);
        chk("blank drop err count", ne, 0);
        chk("glitch dout", dout, 8'h42);

        foreach (tbl[i]) begin
            clr();
            seg_in = tbl[i].seg;
            tick(24);
            chk($sformatf("vec%0d dout", i), dout, tbl[i].dout);
            chk($sformatf("vec%0d valid count", i), nv, tbl[i].nv);
            chk($sformatf("vec%0d err count", i), ne, tbl[i].ne);
        end

        clr();
        rise_c = -1;
        fall_c = -1;
        chk("pre-stale level", stale, 0);
        t0 = cyc;
        seg_in = 8'h19;
        tick(5000);
        chk("stale level", stale, 1);
        chk("stale rise edge", rise_c - t0, 4117);
        t1 = cyc;
        seg_in = 8'hA4;
        tick(40);
        chk("stale fall edge", fall_c - t1, 21);
        chk("stale cleared", stale, 0);
        chk("stale pair dout", dout, 8'h42);
        chk("stale pair valid count", nv, 1);
        chk("stale pair err count", ne, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
